// File: rtl/uart_cmd_pkg.sv
// Shared op codes, FSM state encoding (doubles as the LED code) and command
// field widths for the UART command controller.
package uart_cmd_pkg;

  localparam int CH_W = 6;

  typedef enum logic [1:0] {
    OP_IGN = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_ABT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_PAYLOAD  = 3'b001,
    ST_ISSUE_WR = 3'b010,
    ST_WAIT_WR  = 3'b011,
    ST_ISSUE_RD = 3'b100,
    ST_WAIT_RD  = 3'b101,
    ST_ERROR    = 3'b111
  } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_payload_shift.sv
// MSB-first byte assembler for the write payload: shifts bytes in and flags
// the accept of the last byte so the full word can be captured that same edge.
module cmd_payload_shift
  import uart_cmd_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [7:0]    din,
  output logic [DW-1:0] word_nxt,
  output logic          full
);

  localparam int NB    = DW / 8;
  localparam int CNT_W = $clog2(NB + 1);

  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    shreg;

  // Word as it will look once the current byte is shifted in.
  assign word_nxt = (shreg << 8) | DW'(din);
  assign full     = en && (cnt == CNT_W'(NB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || full) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      shreg <= word_nxt;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes received bytes into one-hot write/read
// start pulses for N_CH engines, with payload assembly, abort and timeout.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = 16,
  parameter int TO_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxrdy,
  input  logic [7:0]      rxdw,
  input  logic [N_CH-1:0] done_wr,
  input  logic [N_CH-1:0] done_rd,
  output logic [N_CH-1:0] start_wr,
  output logic [N_CH-1:0] start_rd,
  output logic [DW-1:0]   wr_data,
  output logic            busy,
  output logic            err,
  output logic [2:0]      sleds
);

  localparam int TO_W = $clog2(TO_CYCLES);

  state_e          state, state_nxt;
  logic [N_CH-1:0] sel_q, sel_nxt, cmd_sel;
  logic [TO_W-1:0] to_cnt, to_nxt;
  op_e             op;
  logic [CH_W-1:0] cmd_ch;
  logic            ch_ok;
  logic            done_hit_wr, done_hit_rd, to_done;
  logic            pl_en, pl_clr, pl_full;
  logic [DW-1:0]   pl_word;

  assign op          = op_e'(rxdw[7:6]);
  assign cmd_ch      = rxdw[CH_W-1:0];
  assign ch_ok       = int'(cmd_ch) < N_CH;
  assign cmd_sel     = N_CH'(1) << cmd_ch;
  assign done_hit_wr = |(done_wr & sel_q);
  assign done_hit_rd = |(done_rd & sel_q);
  assign to_done     = (to_cnt == TO_W'(TO_CYCLES - 1));
  assign pl_en       = (state == ST_PAYLOAD) && rxrdy;
  assign pl_clr      = (state != ST_PAYLOAD);

  cmd_payload_shift #(
    .DW(DW)
  ) u_payload (
    .clk     (clk),
    .rst     (rst),
    .clr     (pl_clr),
    .en      (pl_en),
    .din     (rxdw),
    .word_nxt(pl_word),
    .full    (pl_full)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    to_nxt    = to_cnt;
    case (state)
      ST_IDLE, ST_ERROR: begin
        to_nxt = '0;
        if (rxrdy) begin
          state_nxt = ST_IDLE;
          if (op == OP_WR || op == OP_RD) begin
            if (!ch_ok) begin
              state_nxt = ST_ERROR;
            end else begin
              sel_nxt = cmd_sel;
              if (op == OP_WR) state_nxt = ST_PAYLOAD;
              else             state_nxt = ST_ISSUE_RD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (pl_full) state_nxt = ST_ISSUE_WR;
      end
      ST_ISSUE_WR: begin
        to_nxt    = '0;
        state_nxt = ST_WAIT_WR;
      end
      ST_ISSUE_RD: begin
        to_nxt    = '0;
        state_nxt = ST_WAIT_RD;
      end
      ST_WAIT_WR, ST_WAIT_RD: begin
        to_nxt = to_cnt + 1'b1;
        // done beats abort, abort beats timeout
        if ((state == ST_WAIT_WR) ? done_hit_wr : done_hit_rd) begin
          state_nxt = ST_IDLE;
        end else if (rxrdy && op == OP_ABT) begin
          state_nxt = ST_IDLE;
        end else if (to_done) begin
          state_nxt = ST_ERROR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      to_cnt   <= '0;
      start_wr <= '0;
      start_rd <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      sleds    <= 3'b000;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      to_cnt   <= to_nxt;
      start_wr <= (state_nxt == ST_ISSUE_WR) ? sel_nxt : '0;
      start_rd <= (state_nxt == ST_ISSUE_RD) ? sel_nxt : '0;
      if (pl_full) wr_data <= pl_word;
      busy     <= !(state_nxt == ST_IDLE || state_nxt == ST_ERROR);
      err      <= (state_nxt == ST_ERROR);
      sleds    <= state_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl (N_CH=4, DW=16, TO_CYCLES=8); start
// pulses are matched against a scoreboard of expected issues.
module tb_uart_cmd_ctrl;

  typedef struct {
    bit          is_wr;
    logic [3:0]  sel;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rxrdy;
  logic [7:0]  rxdw;
  logic [3:0]  done_wr, done_rd;
  logic [3:0]  start_wr, start_rd;
  logic [15:0] wr_data;
  logic        busy, err;
  logic [2:0]  sleds;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_cmd_ctrl #(
    .N_CH(4),
    .DW(16),
    .TO_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxrdy   (rxrdy),
    .rxdw    (rxdw),
    .done_wr (done_wr),
    .done_rd (done_rd),
    .start_wr(start_wr),
    .start_rd(start_rd),
    .wr_data (wr_data),
    .busy    (busy),
    .err     (err),
    .sleds   (sleds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock, sample just after the edge, and match any start pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (start_wr !== 4'b0 || start_rd !== 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: start_wr=%b start_rd=%b, required no start", start_wr, start_rd);
      end else begin
        e = sb.pop_front();
        if (e.is_wr) begin
          if (start_wr !== e.sel || start_rd !== 4'b0 || wr_data !== e.data) begin
            errors++;
            $display("FAIL sb_write: start_wr=%b start_rd=%b wr_data=%h, required start_wr=%b start_rd=0000 wr_data=%h",
                     start_wr, start_rd, wr_data, e.sel, e.data);
          end
        end else if (start_rd !== e.sel || start_wr !== 4'b0) begin
          errors++;
          $display("FAIL sb_read: start_rd=%b start_wr=%b, required start_rd=%b start_wr=0000",
                   start_rd, start_wr, e.sel);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxrdy = 1'b1;
    rxdw  = b;
    step();
    rxrdy = 1'b0;
    rxdw  = 8'h00;
  endtask

  task automatic push_exp(input bit is_wr, input logic [3:0] sel, input logic [15:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.sel   = sel;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    step();
    checks++; if (start_wr !== 4'b0) begin errors++; $display("FAIL rst_start_wr: got %b want 0000", start_wr); end
    checks++; if (start_rd !== 4'b0) begin errors++; $display("FAIL rst_start_rd: got %b want 0000", start_rd); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL rst_wr_data: got %h want 0000", wr_data); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b%b want 00", busy, err); end
    checks++; if (sleds !== 3'b000) begin errors++; $display("FAIL rst_sleds: got %b want 000", sleds); end
    rst = 1'b1;
  endtask

  task automatic test_read();
    push_exp(1'b0, 4'b0100, 16'h0);
    send_byte(8'h82);
    checks++; if (sleds !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL rd_issue: sleds=%b busy=%b want 100 1", sleds, busy); end
    step();
    checks++; if (sleds !== 3'b101) begin errors++; $display("FAIL rd_wait: sleds=%b want 101", sleds); end
    step();
    done_rd = 4'b0100;
    step();
    done_rd = 4'b0;
    checks++; if (busy !== 1'b0 || sleds !== 3'b000) begin errors++; $display("FAIL rd_done: busy=%b sleds=%b want 0 000", busy, sleds); end
  endtask

  task automatic test_write();
    send_byte(8'h41);
    checks++; if (sleds !== 3'b001) begin errors++; $display("FAIL wr_payload: sleds=%b want 001", sleds); end
    send_byte(8'hAB);
    push_exp(1'b1, 4'b0010, 16'hABCD);
    send_byte(8'hCD);
    checks++; if (sleds !== 3'b010) begin errors++; $display("FAIL wr_issue: sleds=%b want 010", sleds); end
    step();
    checks++; if (sleds !== 3'b011 || wr_data !== 16'hABCD) begin errors++; $display("FAIL wr_wait: sleds=%b wr_data=%h want 011 abcd", sleds, wr_data); end
    done_wr = 4'b0010;
    step();
    done_wr = 4'b0;
    checks++; if (busy !== 1'b0 || sleds !== 3'b000) begin errors++; $display("FAIL wr_done: busy=%b sleds=%b want 0 000", busy, sleds); end
  endtask

  task automatic test_payload_op11();
    send_byte(8'h43);
    send_byte(8'hC0);
    checks++; if (sleds !== 3'b001) begin errors++; $display("FAIL pl_op11_data: sleds=%b want 001", sleds); end
    push_exp(1'b1, 4'b1000, 16'hC012);
    send_byte(8'h12);
    step();
    done_wr = 4'b1000;
    step();
    done_wr = 4'b0;
    checks++; if (sleds !== 3'b000 || wr_data !== 16'hC012) begin errors++; $display("FAIL pl_op11_end: sleds=%b wr_data=%h want 000 c012", sleds, wr_data); end
  endtask

  task automatic test_bad_channel();
    send_byte(8'h45);
    checks++; if (err !== 1'b1 || sleds !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL bad_ch: err=%b sleds=%b busy=%b want 1 111 0", err, sleds, busy); end
    push_exp(1'b0, 4'b0001, 16'h0);
    send_byte(8'h80);
    checks++; if (err !== 1'b0 || sleds !== 3'b100) begin errors++; $display("FAIL bad_ch_recover: err=%b sleds=%b want 0 100", err, sleds); end
    step();
    done_rd = 4'b0001;
    step();
    done_rd = 4'b0;
    checks++; if (sleds !== 3'b000) begin errors++; $display("FAIL bad_ch_done: sleds=%b want 000", sleds); end
  endtask

  task automatic test_timeout();
    push_exp(1'b0, 4'b1000, 16'h0);
    send_byte(8'h83);
    step();
    checks++; if (sleds !== 3'b101) begin errors++; $display("FAIL to_enter: sleds=%b want 101", sleds); end
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        done_rd = 4'b0001;
        done_wr = 4'b1000;
      end
      step();
      done_rd = 4'b0;
      done_wr = 4'b0;
      if (k < 8) begin
        checks++; if (err !== 1'b0 || sleds !== 3'b101) begin errors++; $display("FAIL to_wait_%0d: err=%b sleds=%b want 0 101", k, err, sleds); end
      end else begin
        checks++; if (err !== 1'b1 || sleds !== 3'b111) begin errors++; $display("FAIL to_expire: err=%b sleds=%b want 1 111", err, sleds); end
      end
    end
    send_byte(8'h00);
    checks++; if (err !== 1'b0 || sleds !== 3'b000) begin errors++; $display("FAIL to_clear: err=%b sleds=%b want 0 000", err, sleds); end
  endtask

  task automatic test_abort();
    send_byte(8'h40);
    send_byte(8'h12);
    push_exp(1'b1, 4'b0001, 16'h1234);
    send_byte(8'h34);
    step();
    send_byte(8'h81);
    checks++; if (sleds !== 3'b011) begin errors++; $display("FAIL abort_drop: sleds=%b want 011", sleds); end
    send_byte(8'hC0);
    checks++; if (sleds !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL abort: sleds=%b busy=%b want 000 0", sleds, busy); end
  endtask

  task automatic test_priority();
    send_byte(8'h40);
    send_byte(8'h56);
    push_exp(1'b1, 4'b0001, 16'h5678);
    send_byte(8'h78);
    step();
    rxrdy = 1'b1; rxdw = 8'hC0; done_wr = 4'b0001;
    step();
    rxrdy = 1'b0; rxdw = 8'h00; done_wr = 4'b0;
    checks++; if (sleds !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL prio_done_abort: sleds=%b err=%b want 000 0", sleds, err); end
    send_byte(8'h42);
    send_byte(8'h9A);
    push_exp(1'b1, 4'b0100, 16'h9ABC);
    send_byte(8'hBC);
    step();
    repeat (7) step();
    done_wr = 4'b0100;
    step();
    done_wr = 4'b0;
    checks++; if (sleds !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL prio_done_timeout: sleds=%b err=%b want 000 0", sleds, err); end
    push_exp(1'b0, 4'b0010, 16'h0);
    send_byte(8'h81);
    step();
    repeat (7) step();
    send_byte(8'hC0);
    checks++; if (sleds !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL prio_abort_timeout: sleds=%b err=%b want 000 0", sleds, err); end
  endtask

  task automatic test_reset_mid_payload();
    send_byte(8'h41);
    send_byte(8'hAB);
    checks++; if (sleds !== 3'b001) begin errors++; $display("FAIL mid_pre: sleds=%b want 001", sleds); end
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || err !== 1'b0 || sleds !== 3'b000) begin errors++; $display("FAIL mid_rst_ctrl: busy=%b err=%b sleds=%b want 0 0 000", busy, err, sleds); end
    checks++; if (wr_data !== 16'h0 || start_wr !== 4'b0 || start_rd !== 4'b0) begin errors++; $display("FAIL mid_rst_data: wr_data=%h start_wr=%b start_rd=%b want 0000 0000 0000", wr_data, start_wr, start_rd); end
    step();
    rst = 1'b1;
    send_byte(8'hCD);
    checks++; if (sleds !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL mid_after: sleds=%b busy=%b want 000 0", sleds, busy); end
    step();
    checks++; if (start_wr !== 4'b0 || wr_data !== 16'h0) begin errors++; $display("FAIL mid_no_start: start_wr=%b wr_data=%h want 0000 0000", start_wr, wr_data); end
  endtask

  initial begin
    rst     = 1'b1;
    rxrdy   = 1'b0;
    rxdw    = 8'h00;
    done_wr = 4'b0;
    done_rd = 4'b0;
    test_reset();
    test_read();
    test_write();
    test_payload_op11();
    test_bad_channel();
    test_timeout();
    test_abort();
    test_priority();
    test_reset_mid_payload();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected starts never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
UART-driven command controller that decodes received bytes into write/read requests for N_CH downstream engines (memory, I2C and similar). It sits between the UART receiver (rxrdy/rxdw) and the engines' start/done handshakes. It generalises the single-channel controller with parametrised channel count and data width, a multi-byte write payload, abort, a timeout watchdog and an error state.

Parameters:
N_CH, 4, number of engine channels (1..64)
DW, 16, write-data width; multiple of 8, 8..64
TO_CYCLES, 1000000, cycles allowed in WAIT before timeout (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rxrdy  in  1  one-cycle strobe: rxdw holds a valid received byte
rxdw  in  8  received byte
done_wr  in  N_CH  per-channel write-complete strobe
done_rd  in  N_CH  per-channel read-complete strobe
start_wr  out  N_CH  one-hot, one-cycle write start
start_rd  out  N_CH  one-hot, one-cycle read start
wr_data  out  DW  write payload; stable from the start_wr cycle until the next write completes its payload
busy  out  1  high in any state other than IDLE/ERROR
err  out  1  high in ERROR
sleds  out  3  state code for the board LEDs

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; start_wr=0, start_rd=0, wr_data=0, busy=0, err=0, sleds=3'b000. Payload counter and timeout counter cleared.
- All outputs are registered.
- Command byte format: rxdw[7:6] is the op (00 ignore, 01 WRITE, 10 READ, 11 ABORT); rxdw[5:0] is the channel. A channel >= N_CH is an error.
- States and sleds codes: IDLE 000, PAYLOAD 001, ISSUE_WR 010, WAIT_WR 011, ISSUE_RD 100, WAIT_RD 101, ERROR 111.
- IDLE/ERROR, on rxrdy:
  - op 01, valid channel: latch channel -> PAYLOAD.
  - op 10, valid channel: latch channel -> ISSUE_RD.
  - op 00 or 11: stay in IDLE; ERROR clears to IDLE.
  - bad channel with op 01/10: -> ERROR.
- PAYLOAD: accept DW/8 bytes, MSB first, into a shift register.
  - A byte whose op is 11 is still data, not an abort; there is no abort during payload.
  - wr_data loads the full word only in the cycle the last byte is accepted, then -> ISSUE_WR.
- ISSUE_WR/ISSUE_RD: last for exactly one cycle. start_wr[ch] or start_rd[ch] is high during that cycle only, then -> WAIT_WR/WAIT_RD. The timeout counter is cleared.
- WAIT_x:
  - done_x[ch] for the selected channel -> IDLE.
  - done strobes on other channels, or on the wrong direction, are ignored.
  - rxrdy with op 11 -> IDLE (abort); any other byte is dropped.
  - counter reaching TO_CYCLES-1 with no done -> ERROR.
- Simultaneous events in WAIT, priority: done > abort > timeout.
- rxrdy during ISSUE states: the byte is dropped.
- Latency:
  - read: command byte sampled at edge t -> start_rd high in cycle t+1.
  - write: last payload byte sampled at edge t -> start_wr high in cycle t+1 with wr_data valid.
  - done sampled at edge t -> busy=0 in cycle t+1.
- N_CH=1: channel field must be 0, otherwise ERROR.
- Mid-operation reset aborts everything immediately, with no start pulse generated.

Decomposition:
- Package uart_cmd_pkg: op codes (OP_IGN, OP_WR, OP_RD, OP_ABT), state enum with the sleds codes, channel field width constant (6).
- Sub-module cmd_payload_shift (parameter DW): byte shift register with byte counter and a one-cycle "full" pulse. The FSM, timeout counter and one-hot start generation stay in the top module.

Test Plan:
1. Read: reset, then byte 0x82 -> start_rd=4'b0100 for one cycle, sleds=101. done_rd[2] two cycles later -> IDLE, busy=0.
2. Write, DW=16: bytes 0x41, 0xAB, 0xCD -> start_wr=4'b0010 one cycle after 0xCD, wr_data=16'hABCD. done_wr[1] -> IDLE.
3. Bad channel: byte 0x45 with N_CH=4 -> ERROR, err=1, sleds=111. Next byte 0x80 -> start_rd=4'b0001, err=0.
4. Timeout: TO_CYCLES=8, byte 0x83, no done -> err=1 exactly 8 cycles after entering WAIT_RD. done_rd[0] (wrong channel) during the wait has no effect.
5. Abort and priority: in WAIT_WR, byte 0xC0 -> IDLE with no done. Repeat with rxrdy=0xC0 and done_wr[ch] in the same cycle -> IDLE via done; then force done and timeout in the same cycle -> IDLE, err=0.
6. Reset mid-payload: after 0x41 and 0xAB, pull rst low -> all outputs 0 immediately. After release, 0xCD alone does not start a write.
